// File: rtl/prom_fetch_ctl_rrarb2.sv
// rtl/prom_fetch_ctl_rrarb2.sv - two-requester round-robin arbiter
module prom_fetch_ctl_rrarb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // Index of the requester served most recently; resets to 1 so requester 0 wins the first tie.
    logic ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b1;
        end else if (update) begin
            ptr <= last;
        end
    end

    always_comb begin
        valid = |req;
        grant = req[1];
        if (req == 2'b11) begin
            grant = ~ptr;
        end
    end

endmodule

// File: rtl/prom_fetch_ctl.sv
// rtl/prom_fetch_ctl.sv - shares one nibble-wide PROM between two word-fetch requesters
module prom_fetch_ctl #(
    parameter int HEIGHT  = 9,
    parameter int WIDTH   = 4,
    parameter int NIBBLES = 2,
    parameter int WAIT    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req0,
    input  logic [HEIGHT-1:0]          addr0,
    output logic                       ack0,
    input  logic                       req1,
    input  logic [HEIGHT-1:0]          addr1,
    output logic                       ack1,
    output logic [WIDTH*NIBBLES-1:0]   data,
    output logic                       busy,
    output logic                       gnt,
    output logic [HEIGHT-1:0]          rom_a,
    output logic                       rom_cs_,
    input  logic [WIDTH-1:0]           rom_q
);

    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int WCW  = (WAIT > 1) ? $clog2(WAIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [IDXW-1:0] idx;
    logic [WCW-1:0]  wcnt;
    logic            arb_grant;
    logic            arb_valid;
    logic            last_wait;
    logic            last_nib;

    prom_fetch_ctl_rrarb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1, req0}),
        .update (state == S_DONE),
        .last   (gnt),
        .grant  (arb_grant),
        .valid  (arb_valid)
    );

    assign last_wait = (wcnt == WCW'(WAIT - 1));
    assign last_nib  = (idx == IDXW'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rom_cs_  = 1'b1;
        busy     = 1'b0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        case (state)
            S_IDLE: begin
                if (arb_valid) begin
                    state_nx = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rom_cs_ = 1'b0;
                busy    = 1'b1;
                if (last_wait && last_nib) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                busy     = 1'b1;
                ack0     = ~gnt;
                ack1     = gnt;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Address and requester are captured only at grant; later req/addr changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_a <= '0;
            gnt   <= 1'b0;
            idx   <= '0;
            wcnt  <= '0;
            data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        gnt   <= arb_grant;
                        rom_a <= arb_grant ? addr1 : addr0;
                        idx   <= '0;
                        wcnt  <= '0;
                    end
                end
                S_ACCESS: begin
                    if (last_wait) begin
                        data[idx*WIDTH +: WIDTH] <= rom_q;
                        wcnt <= '0;
                        if (!last_nib) begin
                            idx   <= idx + IDXW'(1);
                            rom_a <= rom_a + HEIGHT'(1);
                        end
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prom_fetch_ctl.sv
// tb/tb_prom_fetch_ctl.sv - randomized and directed check of prom_fetch_ctl against a transaction model
module tb_prom_fetch_ctl;

    localparam int N  = 2;
    localparam int W  = 1;
    localparam int NW = N * W;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [8:0] addr0 = '0, addr1 = '0;
    logic       ack0, ack1, busy, gnt, rom_cs_;
    logic [7:0] data;
    logic [8:0] rom_a;
    logic [3:0] rom_q;

    logic        b_req0 = 1'b0, b_req1 = 1'b0;
    logic [8:0]  b_addr0 = '0, b_addr1 = '0;
    logic        b_ack0, b_ack1, b_busy, b_gnt, b_rom_cs_;
    logic [15:0] b_data;
    logic [8:0]  b_rom_a;
    logic [3:0]  b_rom_q;

    int n_checks = 0;
    int n_fail   = 0;

    // PROM contents: nibble at address n is n mod 16.
    assign rom_q   = rom_a[3:0];
    assign b_rom_q = b_rom_a[3:0];

    always #5 clk = ~clk;

    prom_fetch_ctl dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .ack1(ack1),
        .data(data), .busy(busy), .gnt(gnt),
        .rom_a(rom_a), .rom_cs_(rom_cs_), .rom_q(rom_q)
    );

    prom_fetch_ctl #(.NIBBLES(4), .WAIT(3)) dut_w (
        .clk(clk), .reset(reset),
        .req0(b_req0), .addr0(b_addr0), .ack0(b_ack0),
        .req1(b_req1), .addr1(b_addr1), .ack1(b_ack1),
        .data(b_data), .busy(b_busy), .gnt(b_gnt),
        .rom_a(b_rom_a), .rom_cs_(b_rom_cs_), .rom_q(b_rom_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: a transfer is a grant plus a cycle offset k (1..NW access, NW+1 done).
    bit         m_active = 1'b0;
    int         m_k      = 0;
    bit         m_who    = 1'b0;
    bit         m_last   = 1'b1;
    bit         m_gnt    = 1'b0;
    logic [8:0] m_addr   = '0;
    logic [8:0] m_rom_a  = '0;
    logic [7:0] m_data   = '0;

    function automatic logic [31:0] word_at(input logic [8:0] a, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) begin
            w |= 32'((a + 9'(i)) % 16) << (4 * i);
        end
        return w;
    endfunction

    function automatic bit m_done();
        return m_active && (m_k == NW + 1);
    endfunction

    task automatic model_step();
        if (reset) begin
            m_active = 1'b0; m_last = 1'b1; m_gnt = 1'b0;
            m_rom_a  = '0;   m_data = '0;   m_k = 0;
        end else if (m_active) begin
            if (m_k == NW + 1) begin
                m_active = 1'b0;
                m_last   = m_who;
            end else begin
                m_k++;
                if (m_k == NW + 1) begin
                    m_data  = 8'(word_at(m_addr, N));
                    m_rom_a = m_addr + 9'(N - 1);
                end else begin
                    m_rom_a = m_addr + 9'((m_k - 1) / W);
                end
            end
        end else if (req0 || req1) begin
            m_who    = (req0 && req1) ? ~m_last : req1;
            m_gnt    = m_who;
            m_addr   = m_who ? addr1 : addr0;
            m_rom_a  = m_addr;
            m_active = 1'b1;
            m_k      = 1;
        end
    endtask

    task automatic check_outputs();
        bit in_acc;
        in_acc = m_active && (m_k <= NW);
        check("ack0", 32'(ack0), 32'(m_done() && !m_who));
        check("ack1", 32'(ack1), 32'(m_done() && m_who));
        check("busy", 32'(busy), 32'(m_active));
        check("rom_cs_", 32'(rom_cs_), 32'(!in_acc));
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("rom_a", 32'(rom_a), 32'(m_rom_a));
        if (!in_acc) check("data", 32'(data), 32'(m_data));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        reset = 1'b1;
        cycle();
        cycle();
        check("rst_cs_", 32'(rom_cs_), 32'd1);
        check("rst_data", 32'(data), 32'd0);
        reset = 1'b0;

        // Single fetch from 0x012.
        req0 = 1'b1; addr0 = 9'h012;
        cycle(); check("sf_a0", 32'(rom_a), 32'h012); check("sf_cs0", 32'(rom_cs_), 32'd0);
        cycle(); check("sf_a1", 32'(rom_a), 32'h013);
        cycle(); check("sf_ack0", 32'(ack0), 32'd1); check("sf_data", 32'(data), 32'h32);
        check("sf_ack1", 32'(ack1), 32'd0);
        req0 = 1'b0;
        cycle();

        // Address wrap 0x1FF -> 0x000.
        req1 = 1'b1; addr1 = 9'h1FF;
        cycle(); check("wr_a0", 32'(rom_a), 32'h1FF);
        cycle(); check("wr_a1", 32'(rom_a), 32'h000);
        cycle(); check("wr_ack1", 32'(ack1), 32'd1); check("wr_data", 32'(data), 32'h0F);
        req1 = 1'b0;
        cycle(); check("wr_pulse", 32'(ack1), 32'd0);

        // Simultaneous held requests after reset alternate 0,1,0.
        reset = 1'b1; cycle(); reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 9'h004; addr1 = 9'h008;
        for (int c = 0; c <= 10; c++) begin
            cycle();
            if (c == 2)  begin check("alt_ack0", 32'(ack0), 32'd1); check("alt_d0", 32'(data), 32'h54); end
            if (c == 6)  begin check("alt_ack1", 32'(ack1), 32'd1); check("alt_d1", 32'(data), 32'h98); end
            if (c == 10) begin check("alt_ack0b", 32'(ack0), 32'd1); check("alt_d2", 32'(data), 32'h54); end
        end
        req0 = 1'b0; req1 = 1'b0;
        cycle();

        // Reset during nibble 1 aborts; the pointer restarts with requester 0.
        req0 = 1'b1; addr0 = 9'h030;
        cycle(); cycle();
        reset = 1'b1;
        cycle();
        check("ra_cs_", 32'(rom_cs_), 32'd1); check("ra_busy", 32'(busy), 32'd0);
        check("ra_data", 32'(data), 32'd0);   check("ra_ack", 32'({ack1, ack0}), 32'd0);
        reset = 1'b0; req1 = 1'b1; addr1 = 9'h040;
        cycle(); check("ra_gnt", 32'(gnt), 32'd0); check("ra_addr", 32'(rom_a), 32'h030);
        cycle(); cycle();
        check("ra_ack0", 32'(ack0), 32'd1); check("ra_d0", 32'(data), 32'h10);
        req0 = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        check("ra_ack1", 32'(ack1), 32'd1); check("ra_d1", 32'(data), 32'h10);
        req1 = 1'b0;
        cycle();

        // Wide/slow instance: NIBBLES=4, WAIT=3 from 0x020.
        b_req0 = 1'b1; b_addr0 = 9'h020;
        for (int c = 1; c <= 14; c++) begin
            cycle();
            if (c <= 12) begin
                check("w_rom_a", 32'(b_rom_a), 32'h020 + 32'((c - 1) / 3));
                check("w_cs_", 32'(b_rom_cs_), 32'd0);
            end
            check("w_ack0", 32'(b_ack0), 32'(c == 13));
            if (c == 13) begin
                check("w_data", 32'(b_data), 32'h3210);
                b_req0 = 1'b0;
            end
        end

        // Randomized traffic, including addr changes mid-transfer and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            bit a0, a1;
            a0 = m_done() && !m_who;
            a1 = m_done() && m_who;
            if (req0 && a0) begin
                req0 = 1'($urandom_range(0, 1)); addr0 = 9'($urandom_range(0, 511));
            end else if (req0) begin
                if ($urandom_range(0, 3) == 0) addr0 = 9'($urandom_range(0, 511));
            end else if ($urandom_range(0, 2) == 0) begin
                req0 = 1'b1; addr0 = 9'($urandom_range(0, 511));
            end
            if (req1 && a1) begin
                req1 = 1'($urandom_range(0, 1)); addr1 = 9'($urandom_range(0, 511));
            end else if (req1) begin
                if ($urandom_range(0, 3) == 0) addr1 = 9'($urandom_range(0, 511));
            end else if ($urandom_range(0, 2) == 0) begin
                req1 = 1'b1; addr1 = 9'($urandom_range(0, 511));
            end
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end

        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
